// File: rtl/count_sched_pkg.sv
// Shared types and constants for the two-requester count scheduler.
// Saturation limits here are for the default width; the core derives its own from W.
package count_sched_pkg;

   localparam int W_DEF     = 8;
   localparam int LEN_W_DEF = 4;

   localparam int SAT_MAX = (2 ** (W_DEF - 1)) - 1;
   localparam int SAT_MIN = -(2 ** (W_DEF - 1));

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/count_sched_if.sv
// Requester-facing bundle of the count scheduler: job requests in, grants/status out.
interface count_sched_if
   import count_sched_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int LEN_W = LEN_W_DEF
);
   logic                    req0;
   logic                    req1;
   logic signed [W-1:0]     step0;
   logic signed [W-1:0]     step1;
   logic        [LEN_W-1:0] len0;
   logic        [LEN_W-1:0] len1;
   logic                    gnt0;
   logic                    gnt1;
   logic signed [W-1:0]     count;
   logic                    busy;
   logic                    owner;
   logic                    done0;
   logic                    done1;
   logic                    sat;

   modport master (
      output req0, req1, step0, step1, len0, len1,
      input  gnt0, gnt1, count, busy, owner, done0, done1, sat
   );

   modport slave (
      input  req0, req1, step0, step1, len0, len1,
      output gnt0, gnt1, count, busy, owner, done0, done1, sat
   );
endinterface

// File: rtl/count_core.sv
// Signed saturating accumulator: clr zeroes it, en adds step with clamping.
// sat_hit flags that the addition enabled this cycle was clamped.
module count_core
   import count_sched_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                en,
   input  logic signed [W-1:0] step,
   output logic signed [W-1:0] count,
   output logic                sat_hit
);
   localparam logic signed [W:0] MAX_V = {2'b00, {(W-1){1'b1}}};
   localparam logic signed [W:0] MIN_V = {2'b11, {(W-1){1'b0}}};

   logic signed [W-1:0] count_r;
   logic signed [W:0]   sum_s;
   logic signed [W-1:0] next_s;
   logic                clamp_s;

   // One-bit-wider sum, then clamp into the W-bit signed range
   always_comb begin
      sum_s   = {count_r[W-1], count_r} + {step[W-1], step};
      next_s  = sum_s[W-1:0];
      clamp_s = 1'b0;
      if (sum_s > MAX_V) begin
         next_s  = MAX_V[W-1:0];
         clamp_s = 1'b1;
      end else if (sum_s < MIN_V) begin
         next_s  = MIN_V[W-1:0];
         clamp_s = 1'b1;
      end else begin
         next_s  = sum_s[W-1:0];
         clamp_s = 1'b0;
      end
   end

   // Accumulator register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= '0;
      end else if (clr) begin
         count_r <= '0;
      end else if (en) begin
         count_r <= next_s;
      end else begin
         count_r <= count_r;
      end
   end

   assign count   = count_r;
   assign sat_hit = en & clamp_s;

endmodule

// File: rtl/count_sched.sv
// Round-robin scheduler time-sharing one saturating counter between two requesters.
// A job clears the counter, runs LEN additions, then pulses DONE to its owner.
module count_sched
   import count_sched_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int LEN_W = LEN_W_DEF
) (
   input logic          clk,
   input logic          rst_n,
   count_sched_if.slave bus
);
   localparam logic [LEN_W-1:0] ONE_LEN = {{(LEN_W-1){1'b0}}, 1'b1};

   state_t              state_r;
   logic                prio_r;
   logic                owner_r;
   logic                gnt0_r;
   logic                gnt1_r;
   logic                done0_r;
   logic                done1_r;
   logic                busy_r;
   logic                sat_r;
   logic signed [W-1:0] step_r;
   logic [LEN_W-1:0]    rem_r;

   logic                req_any_s;
   logic                pick_s;
   logic                clr_s;
   logic                en_s;
   logic                sat_hit_s;
   logic signed [W-1:0] count_s;

   // Arbitration: a lone request wins; on a tie prio_r names the winner
   always_comb begin
      req_any_s = bus.req0 | bus.req1;
      if (bus.req0 && bus.req1) begin
         pick_s = prio_r;
      end else begin
         pick_s = bus.req1;
      end
   end

   // Core control decoded from registered state
   always_comb begin
      clr_s = (state_r == ST_IDLE) && req_any_s;
      en_s  = (state_r == ST_RUN) && (rem_r != '0);
   end

   count_core #(.W(W)) u_core (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr_s),
      .en      (en_s),
      .step    (step_r),
      .count   (count_s),
      .sat_hit (sat_hit_s)
   );

   // Scheduler FSM with registered grant/done/status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         prio_r  <= 1'b0;
         owner_r <= 1'b0;
         gnt0_r  <= 1'b0;
         gnt1_r  <= 1'b0;
         done0_r <= 1'b0;
         done1_r <= 1'b0;
         busy_r  <= 1'b0;
         sat_r   <= 1'b0;
         step_r  <= '0;
         rem_r   <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done0_r <= 1'b0;
               done1_r <= 1'b0;
               if (req_any_s) begin
                  owner_r <= pick_s;
                  step_r  <= pick_s ? bus.step1 : bus.step0;
                  rem_r   <= pick_s ? bus.len1 : bus.len0;
                  gnt0_r  <= ~pick_s;
                  gnt1_r  <= pick_s;
                  busy_r  <= 1'b1;
                  sat_r   <= 1'b0;
                  state_r <= ST_RUN;
               end else begin
                  gnt0_r  <= 1'b0;
                  gnt1_r  <= 1'b0;
               end
            end
            ST_RUN: begin
               gnt0_r <= 1'b0;
               gnt1_r <= 1'b0;
               if (sat_hit_s) begin
                  sat_r <= 1'b1;
               end
               // rem reaching zero still spends one RUN cycle before DONE
               if (rem_r != '0) begin
                  rem_r <= rem_r - ONE_LEN;
               end else begin
                  done0_r <= ~owner_r;
                  done1_r <= owner_r;
                  state_r <= ST_DONE;
               end
            end
            ST_DONE: begin
               done0_r <= 1'b0;
               done1_r <= 1'b0;
               busy_r  <= 1'b0;
               prio_r  <= ~owner_r;
               state_r <= ST_IDLE;
            end
            default: begin
               gnt0_r  <= 1'b0;
               gnt1_r  <= 1'b0;
               done0_r <= 1'b0;
               done1_r <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.gnt0  = gnt0_r;
   assign bus.gnt1  = gnt1_r;
   assign bus.done0 = done0_r;
   assign bus.done1 = done1_r;
   assign bus.busy  = busy_r;
   assign bus.owner = owner_r;
   assign bus.sat   = sat_r;
   assign bus.count = count_s;

endmodule

// File: tb/tb_count_sched.sv
// Directed bench for count_sched: per-cycle expected flags and counts, sampled on negedge.
// Flag vector order: {gnt0, gnt1, done0, done1, busy, owner, sat}.
module tb_count_sched;

   logic clk;
   logic rst_n;
   int   vec_cnt;
   int   err_cnt;

   count_sched_if #(.W(8), .LEN_W(4)) bus ();

   count_sched #(.W(8), .LEN_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [6:0] flags_s;
   assign flags_s = {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.owner, bus.sat};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #1;
      vec_cnt++;
      if (flags_s !== 7'b0000000) begin
         err_cnt++;
         $display("FAIL reset_flags: got %b expected %b", flags_s, 7'b0000000);
      end
      vec_cnt++;
      if (bus.count !== 8'sd0) begin
         err_cnt++;
         $display("FAIL reset_count: got %0d expected 0", bus.count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      vec_cnt++;
      if (flags_s !== 7'b0000000) begin
         err_cnt++;
         $display("FAIL reset_idle_flags: got %b expected %b", flags_s, 7'b0000000);
      end
   endtask

   task automatic test_single_job();
      logic [6:0]        fl [0:7] = '{7'b1000100, 7'b0000100, 7'b0000100, 7'b0000100,
                                      7'b0000100, 7'b0000100, 7'b0010100, 7'b0000000};
      logic signed [7:0] cn [0:7] = '{8'sd0, 8'sd10, 8'sd20, 8'sd30, 8'sd40, 8'sd50, 8'sd50, 8'sd50};
      do_reset();
      bus.req0  = 1'b1;
      bus.step0 = 8'sd10;
      bus.len0  = 4'd5;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         vec_cnt++;
         if (flags_s !== fl[i]) begin
            err_cnt++;
            $display("FAIL single_flags[%0d]: got %b expected %b", i, flags_s, fl[i]);
         end
         vec_cnt++;
         if (bus.count !== cn[i]) begin
            err_cnt++;
            $display("FAIL single_count[%0d]: got %0d expected %0d", i, bus.count, cn[i]);
         end
         if (i == 0) bus.req0 = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0]        fl [0:10] = '{7'b1000100, 7'b0000100, 7'b0000100, 7'b0010100,
                                       7'b0000000, 7'b0100110, 7'b0000110, 7'b0000110,
                                       7'b0001110, 7'b0000010, 7'b1000100};
      logic signed [7:0] cn [0:10] = '{8'sd0, 8'sd1, 8'sd2, 8'sd2, 8'sd2, 8'sd0,
                                       -8'sd3, -8'sd6, -8'sd6, -8'sd6, 8'sd0};
      do_reset();
      bus.req0  = 1'b1;
      bus.req1  = 1'b1;
      bus.step0 = 8'sd1;
      bus.len0  = 4'd2;
      bus.step1 = -8'sd3;
      bus.len1  = 4'd2;
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         vec_cnt++;
         if (flags_s !== fl[i]) begin
            err_cnt++;
            $display("FAIL rr_flags[%0d]: got %b expected %b", i, flags_s, fl[i]);
         end
         vec_cnt++;
         if (bus.count !== cn[i]) begin
            err_cnt++;
            $display("FAIL rr_count[%0d]: got %0d expected %0d", i, bus.count, cn[i]);
         end
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
   endtask

   task automatic test_pos_sat();
      logic [6:0]        fl [0:6] = '{7'b1000100, 7'b0000100, 7'b0000101, 7'b0000101,
                                      7'b0010101, 7'b0000001, 7'b0100110};
      logic signed [7:0] cn [0:6] = '{8'sd0, 8'sd100, 8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd0};
      do_reset();
      bus.req0  = 1'b1;
      bus.step0 = 8'sd100;
      bus.len0  = 4'd3;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         vec_cnt++;
         if (flags_s !== fl[i]) begin
            err_cnt++;
            $display("FAIL possat_flags[%0d]: got %b expected %b", i, flags_s, fl[i]);
         end
         vec_cnt++;
         if (bus.count !== cn[i]) begin
            err_cnt++;
            $display("FAIL possat_count[%0d]: got %0d expected %0d", i, bus.count, cn[i]);
         end
         if (i == 0) bus.req0 = 1'b0;
         if (i == 5) begin
            bus.req1  = 1'b1;
            bus.step1 = 8'sd1;
            bus.len1  = 4'd1;
         end
      end
      bus.req1 = 1'b0;
   endtask

   task automatic test_neg_sat();
      logic [6:0]        fl [0:5] = '{7'b0100110, 7'b0000110, 7'b0000110, 7'b0000111,
                                      7'b0001111, 7'b0000011};
      logic signed [7:0] cn [0:5] = '{8'sd0, -8'sd50, -8'sd100, -8'sd128, -8'sd128, -8'sd128};
      do_reset();
      bus.req1  = 1'b1;
      bus.step1 = -8'sd50;
      bus.len1  = 4'd3;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         vec_cnt++;
         if (flags_s !== fl[i]) begin
            err_cnt++;
            $display("FAIL negsat_flags[%0d]: got %b expected %b", i, flags_s, fl[i]);
         end
         vec_cnt++;
         if (bus.count !== cn[i]) begin
            err_cnt++;
            $display("FAIL negsat_count[%0d]: got %0d expected %0d", i, bus.count, cn[i]);
         end
         if (i == 0) bus.req1 = 1'b0;
      end
   endtask

   task automatic test_zero_len();
      logic [6:0] fl [0:2] = '{7'b1000100, 7'b0010100, 7'b0000000};
      do_reset();
      bus.req0  = 1'b1;
      bus.step0 = 8'sd77;
      bus.len0  = 4'd0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vec_cnt++;
         if (flags_s !== fl[i]) begin
            err_cnt++;
            $display("FAIL zero_flags[%0d]: got %b expected %b", i, flags_s, fl[i]);
         end
         vec_cnt++;
         if (bus.count !== 8'sd0) begin
            err_cnt++;
            $display("FAIL zero_count[%0d]: got %0d expected 0", i, bus.count);
         end
         if (i == 0) bus.req0 = 1'b0;
      end
   endtask

   task automatic test_reset_mid_run();
      logic signed [7:0] cn [0:2] = '{8'sd0, 8'sd10, 8'sd20};
      do_reset();
      bus.req0  = 1'b1;
      bus.step0 = 8'sd10;
      bus.len0  = 4'd5;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vec_cnt++;
         if (bus.count !== cn[i]) begin
            err_cnt++;
            $display("FAIL midrst_count[%0d]: got %0d expected %0d", i, bus.count, cn[i]);
         end
      end
      bus.req1 = 1'b1;
      rst_n    = 1'b0;
      #1;
      vec_cnt++;
      if (flags_s !== 7'b0000000 || bus.count !== 8'sd0) begin
         err_cnt++;
         $display("FAIL midrst_async: got flags %b count %0d expected 0000000 / 0", flags_s, bus.count);
      end
      @(negedge clk);
      vec_cnt++;
      if (flags_s !== 7'b0000000) begin
         err_cnt++;
         $display("FAIL midrst_held: got %b expected %b", flags_s, 7'b0000000);
      end
      rst_n = 1'b1;
      @(negedge clk);
      vec_cnt++;
      if (flags_s !== 7'b1000100) begin
         err_cnt++;
         $display("FAIL midrst_regrant: got %b expected %b", flags_s, 7'b1000100);
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   initial begin
      vec_cnt   = 0;
      err_cnt   = 0;
      rst_n     = 1'b0;
      bus.req0  = 1'b0;
      bus.req1  = 1'b0;
      bus.step0 = 8'sd0;
      bus.step1 = 8'sd0;
      bus.len0  = 4'd0;
      bus.len1  = 4'd0;
      test_reset();
      test_single_job();
      test_back_to_back();
      test_pos_sat();
      test_neg_sat();
      test_zero_len();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
